hit_word_select: RTL and testbench

- Cache read-datapath slice: gates each way's data block onto a shared block bus using per-way hit enables (tri-state style), then selects one 32-bit word by block offset.
- Sits after tag compare / data-array read in the cache controller, and feeds the CPU read-data return.
- Output is registered: one clock of latency, with hit and multi-hit status.

---
 rtl/hit_word_select_pkg.sv | 10 +
 rtl/way_tristate_gate.sv | 14 +
 rtl/hit_word_select.sv | 92 +++++++++
 tb/tb_hit_word_select.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/hit_word_select_pkg.sv
// Shared sizing constants for the hit-word-select read slice.
// Block and word widths, words per block and offset width.
package hit_word_select_pkg;

    localparam int DEF_BLOCK_BITS  = 128;
    localparam int DEF_WORD_BITS   = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFFSET_BITS     = 2;

endpackage : hit_word_select_pkg

// File: rtl/way_tristate_gate.sv
// Per-way tri-state gate: drives the block when enabled, else floats.
// Only used internally; the top never registers a floating value.
module way_tristate_gate #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] a,
    input  logic             enable,
    output logic [WIDTH-1:0] b
);

    // Drive the way's data only while its hit enable is high
    assign b = enable ? a : {WIDTH{1'bz}};

endmodule : way_tristate_gate

// File: rtl/hit_word_select.sv
// Cache read slice: gates way blocks by hit, picks way 0 first,
// selects one word by offset, and registers word/hit/multi-hit.
module hit_word_select
    import hit_word_select_pkg::*;
#(
    parameter int BLOCK_BITS = DEF_BLOCK_BITS,
    parameter int WORD_BITS  = DEF_WORD_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BLOCK_BITS-1:0]  db_read_0,
    input  logic [BLOCK_BITS-1:0]  db_read_1,
    input  logic                   hit_way_0,
    input  logic                   hit_way_1,
    input  logic [OFFSET_BITS-1:0] block_offset,
    output logic [WORD_BITS-1:0]   word_out,
    output logic                   hit_out,
    output logic                   multi_hit
);

    // The word mux assumes exactly four words per block
    if (BLOCK_BITS != WORDS_PER_BLOCK * WORD_BITS) begin : g_width_chk
        $fatal(1, "hit_word_select: BLOCK_BITS must be 4*WORD_BITS");
    end

    logic [BLOCK_BITS-1:0] w_gated_0;
    logic [BLOCK_BITS-1:0] w_gated_1;
    logic [BLOCK_BITS-1:0] w_block;
    logic [WORD_BITS-1:0]  w_word;
    logic                  w_any_hit;
    logic                  w_both_hit;

    logic [WORD_BITS-1:0]  r_word;
    logic                  r_hit;
    logic                  r_multi;

    way_tristate_gate #(.WIDTH(BLOCK_BITS)) u_gate_0 (
        .a      (db_read_0),
        .enable (hit_way_0),
        .b      (w_gated_0)
    );

    way_tristate_gate #(.WIDTH(BLOCK_BITS)) u_gate_1 (
        .a      (db_read_1),
        .enable (hit_way_1),
        .b      (w_gated_1)
    );

    assign w_any_hit  = hit_way_0 | hit_way_1;
    assign w_both_hit = hit_way_0 & hit_way_1;

    // Way 0 has priority; on a miss the result is forced to zero
    // so a floating bus can never reach the word register
    always_comb begin
        w_block = '0;
        if (hit_way_0) begin
            w_block = w_gated_0;
        end else if (hit_way_1) begin
            w_block = w_gated_1;
        end
    end

    // Pick the addressed word out of the selected block
    always_comb begin
        w_word = '0;
        case (block_offset)
            2'd0: w_word = w_block[WORD_BITS-1:0];
            2'd1: w_word = w_block[2*WORD_BITS-1:WORD_BITS];
            2'd2: w_word = w_block[3*WORD_BITS-1:2*WORD_BITS];
            2'd3: w_word = w_block[4*WORD_BITS-1:3*WORD_BITS];
            default: w_word = '0;
        endcase
    end

    // Output register stage with synchronous reset priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= '0;
            r_hit   <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_word  <= w_any_hit ? w_word : '0;
            r_hit   <= w_any_hit;
            r_multi <= w_both_hit;
        end
    end

    assign word_out  = r_word;
    assign hit_out   = r_hit;
    assign multi_hit = r_multi;

endmodule : hit_word_select

// File: tb/tb_hit_word_select.sv
// Self-checking bench for hit_word_select: directed vector table,
// hand-written reset sequences and a randomized reference-model run.
module tb_hit_word_select;

    logic         clk;
    logic         rst;
    logic [127:0] db_read_0;
    logic [127:0] db_read_1;
    logic         hit_way_0;
    logic         hit_way_1;
    logic [1:0]   block_offset;
    logic [31:0]  word_out;
    logic         hit_out;
    logic         multi_hit;

    int n_checks;
    int n_fails;

    typedef struct {
        logic         rst;
        logic [127:0] d0;
        logic [127:0] d1;
        logic         h0;
        logic         h1;
        logic [1:0]   off;
        logic [31:0]  exp_word;
        logic         exp_hit;
        logic         exp_multi;
        string        name;
    } vec_t;

    vec_t vecs[$];

    hit_word_select dut (
        .clk          (clk),
        .rst          (rst),
        .db_read_0    (db_read_0),
        .db_read_1    (db_read_1),
        .hit_way_0    (hit_way_0),
        .hit_way_1    (hit_way_1),
        .block_offset (block_offset),
        .word_out     (word_out),
        .hit_out      (hit_out),
        .multi_hit    (multi_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick the hitting block (way 0 first), shift the word down
    function automatic logic [31:0] ref_word(
        input logic [127:0] d0, input logic [127:0] d1,
        input logic h0, input logic h1, input logic [1:0] off);
        logic [127:0] blk;
        if (!(h0 || h1)) return 32'h0;
        blk = h0 ? d0 : d1;
        return 32'(blk >> (32 * int'(off)));
    endfunction

    task automatic drive(input logic r, input logic [127:0] d0,
                         input logic [127:0] d1, input logic h0,
                         input logic h1, input logic [1:0] off);
        rst          = r;
        db_read_0    = d0;
        db_read_1    = d1;
        hit_way_0    = h0;
        hit_way_1    = h1;
        block_offset = off;
    endtask

    task automatic check(input string name, input logic [31:0] ew,
                         input logic eh, input logic em);
        n_checks++;
        if (word_out !== ew || hit_out !== eh || multi_hit !== em) begin
            n_fails++;
            $display("FAIL %s: got word=%h hit=%b multi=%b, want word=%h hit=%b multi=%b",
                     name, word_out, hit_out, multi_hit, ew, eh, em);
        end
    endtask

    task automatic step_check(input string name, input logic [31:0] ew,
                              input logic eh, input logic em);
        @(posedge clk);
        #1;
        check(name, ew, eh, em);
    endtask

    function automatic void add(input string name, input logic r,
        input logic [127:0] d0, input logic [127:0] d1,
        input logic h0, input logic h1, input logic [1:0] off,
        input logic [31:0] ew, input logic eh, input logic em);
        vec_t v;
        v.name = name; v.rst = r; v.d0 = d0; v.d1 = d1;
        v.h0 = h0; v.h1 = h1; v.off = off;
        v.exp_word = ew; v.exp_hit = eh; v.exp_multi = em;
        vecs.push_back(v);
    endfunction

    localparam logic [127:0] DA = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] DB = 128'h0000_0000_0000_0000_1111_1111_1111_1111;
    localparam logic [127:0] DW = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

    initial begin
        n_checks = 0;
        n_fails  = 0;

        add("reset0",  1, DA, DB, 1, 0, 0, 32'h0, 0, 0);
        add("reset1",  1, DA, DB, 1, 0, 0, 32'h0, 0, 0);
        add("nohit",   0, DA, DB, 0, 0, 0, 32'h0, 0, 0);
        add("w0_off0", 0, DA, DB, 1, 0, 0, 32'hFFFF_FFFF, 1, 0);
        add("w0_off1", 0, DA, DB, 1, 0, 1, 32'hFFFF_FFFF, 1, 0);
        add("w0_off2", 0, DA, DB, 1, 0, 2, 32'h0, 1, 0);
        add("w0_off3", 0, DA, DB, 1, 0, 3, 32'h0, 1, 0);
        add("w1_off0", 0, DA, DB, 0, 1, 0, 32'h1111_1111, 1, 0);
        add("w1_off1", 0, DA, DB, 0, 1, 1, 32'h1111_1111, 1, 0);
        add("w1_off3", 0, DA, DB, 0, 1, 3, 32'h0, 1, 0);
        add("both",    0, DA, DB, 1, 1, 0, 32'hFFFF_FFFF, 1, 1);
        add("walk0",   0, DW, DB, 1, 0, 0, 32'h1111_1111, 1, 0);
        add("walk1",   0, DW, DB, 1, 0, 1, 32'h2222_2222, 1, 0);
        add("walk2",   0, DW, DB, 1, 0, 2, 32'h3333_3333, 1, 0);
        add("walk3",   0, DW, DB, 1, 0, 3, 32'h4444_4444, 1, 0);
        add("w1_walk2",0, DA, DW, 0, 1, 2, 32'h3333_3333, 1, 0);
        add("miss_end",0, DW, DW, 0, 0, 3, 32'h0, 0, 0);

        drive(1, '0, '0, 0, 0, 0);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].d0, vecs[i].d1,
                  vecs[i].h0, vecs[i].h1, vecs[i].off);
            step_check(vecs[i].name, vecs[i].exp_word,
                       vecs[i].exp_hit, vecs[i].exp_multi);
        end

        // Reset mid-stream clears at that edge, valid data one cycle after
        @(negedge clk);
        drive(0, DW, DB, 1, 1, 2);
        step_check("pre_rst", 32'h3333_3333, 1, 1);
        @(negedge clk);
        drive(1, DW, DB, 1, 1, 2);
        step_check("mid_rst", 32'h0, 0, 0);
        @(negedge clk);
        drive(0, DW, DB, 0, 1, 1);
        step_check("post_rst", 32'h1111_1111, 1, 0);

        // Randomized run against the reference model
        for (int k = 0; k < 300; k++) begin
            logic [127:0] d0, d1;
            logic h0, h1, r;
            logic [1:0] off;
            @(negedge clk);
            d0  = {$urandom, $urandom, $urandom, $urandom};
            d1  = {$urandom, $urandom, $urandom, $urandom};
            h0  = 1'($urandom_range(0, 1));
            h1  = 1'($urandom_range(0, 1));
            off = 2'($urandom_range(0, 3));
            r   = ($urandom_range(0, 19) == 0);
            drive(r, d0, d1, h0, h1, off);
            if (r)
                step_check("rand_rst", 32'h0, 0, 0);
            else
                step_check("rand", ref_word(d0, d1, h0, h1, off),
                           h0 | h1, h0 & h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule : tb_hit_word_select
